i2s_rx_deser: RTL and testbench
===============================

Name: i2s_rx_deser

Overview:
- I2S receive deserializer; the capture-side counterpart of the CS4334 transmit stage. Runs in the MCLKIN domain (MCLK = 8 × SCLK, 64 SCLK per frame).
- Synchronises external SCLK/LRCLK/SDIN, detects SCLK rising edges and strips the I2S one-bit delay.
- Assembles MSB-first samples into parallel left/right words with single-cycle valid strobes.
- Output feeds the DDS/loopback checker and can drive L_DIN/R_DIN with L_EN/R_EN of the transmit stage directly.

Parameters:
- DATA_W, 16, captured sample width (bits kept per slot, MSB first).
- SLOT_W, 32, nominal SCLK periods per channel slot; used for overrun detection.

Ports:
- MCLKIN  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- SCLK_IN  in  1  external serial clock (asynchronous to MCLKIN).
- LRCLK_IN  in  1  external word select; 0 = left, 1 = right.
- SDIN  in  1  serial data.
- L_DOUT  out  DATA_W  last complete left sample.
- R_DOUT  out  DATA_W  last complete right sample.
- L_VALID  out  1  one-cycle pulse when L_DOUT updates.
- R_VALID  out  1  one-cycle pulse when R_DOUT updates.
- FRAME_ERR  out  1  sticky; set on short slot or slot overrun; cleared only by RST.
- LOCKED  out  1  high once the first LRCLK transition has been seen.

Behaviour:
- Reset (sync, RST=1 at posedge MCLKIN):
  - All outputs, shift register, bit counter and synchroniser flops go to 0; FSM enters IDLE.
  - Reset mid-slot discards the partial sample; no valid pulse is generated.
- Input conditioning:
  - SCLK_IN, LRCLK_IN and SDIN each pass through a 2-FF synchroniser plus one history flop.
  - sclk_rise = sync & ~hist. LRCLK and SDIN are sampled only on sclk_rise cycles, giving lr_smp and sd_smp.
  - lr_prev holds the previous lr_smp.
- FSM:
  - IDLE:
    - On sclk_rise with lr_smp != lr_prev: go to SHIFT, bit_cnt = 0, ch = lr_smp, LOCKED = 1.
    - That SCLK edge is the I2S delay bit; its data is not shifted.
    - Before the first transition, lr_prev simply tracks lr_smp.
  - SHIFT:
    - Each sclk_rise shifts sd_smp into the LSB of sh[DATA_W-1:0]; bit_cnt increments.
    - When bit_cnt reaches DATA_W-1 and the edge shifts: on the next MCLKIN cycle, load {sh[DATA_W-2:0], sd_smp} into L_DOUT (ch=0) or R_DOUT (ch=1), pulse the matching VALID for exactly one cycle, then go to DRAIN.
  - DRAIN:
    - Counts the remaining sclk_rise edges of the slot (bit_cnt continues); data is ignored.
    - An LRCLK transition restarts the slot exactly as in IDLE (new delay bit, next ch).
  - SHIFT with an LRCLK transition before DATA_W bits are captured:
    - Set FRAME_ERR, discard the partial sample (no valid pulse), restart the slot for the new channel.
- Overrun: if bit_cnt reaches SLOT_W+1 without an LRCLK transition, set FRAME_ERR and go to IDLE (relock). bit_cnt is 6 bits and saturates, never wraps.
- Latency: the valid pulse is asserted 4 MCLKIN cycles after the SCLK_IN rising edge carrying the sample LSB (2 sync + 1 edge detect + 1 output register).
- Simultaneous events: if an LRCLK transition lands on the same sclk_rise as a slot completion, the output/valid update for the finishing slot wins, and the new slot starts on that same edge.
- L_DOUT and R_DOUT hold their value until their next valid load.
- FRAME_ERR has no effect on later captures.
- Only one VALID can be high in any cycle.

Decomposition:
- Shared package i2s_pkg:
  - Constants MCLK_PER_SCLK=8, SCLK_PER_FRAME=64, SLOT_W=32.
  - FSM state encoding IDLE/SHIFT/DRAIN.
  - Channel encoding LEFT=0/RIGHT=1.
- Sub-module i2s_sync_edge: 2-FF synchroniser plus history flop with rise/fall outputs, instantiated for SCLK_IN and LRCLK_IN (SDIN uses the sync only).

Test Plan:
- Bench drives standard I2S at MCLK/8, L=16'hA5C3, R=16'h0F0F -> L_VALID once with L_DOUT=16'hA5C3, then R_VALID once with R_DOUT=16'h0F0F; FRAME_ERR=0; LOCKED=1 after the first LRCLK edge.
- Stream of 8 frames with L=n, R=~n (n=0..7) -> 16 valid pulses strictly alternating L/R, values exact, interval 256 MCLKIN cycles per channel pair.
- Short slot: LRCLK toggles after 10 left bits -> no L_VALID for that slot, FRAME_ERR=1, following right sample 16'h1234 captured correctly.
- Stuck LRCLK for 40 SCLK periods -> FRAME_ERR=1, FSM back in IDLE, recapture correct after the next LRCLK edge.
- RST asserted for 1 cycle mid-left-slot -> all outputs 0 next cycle, LOCKED=0, no spurious VALID; capture resumes after the next LRCLK transition.
- Start mid-frame (bench begins 7 SCLK into the right slot) -> no VALID until the first full slot; first capture is a left sample with the correct value.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants, FSM/channel encodings and helpers for the I2S receive path.
package i2s_pkg;

    localparam int unsigned MCLK_PER_SCLK  = 8;
    localparam int unsigned SCLK_PER_FRAME = 64;
    localparam int unsigned SLOT_W         = 32;
    localparam int unsigned CNT_W          = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

    // Bit counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser with a history flop providing rise/fall detection.
module i2s_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o_c,
    output logic fall_o_c
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign sync_o   = sync_q;
    assign rise_o_c = sync_q & ~hist_q;
    assign fall_o_c = ~sync_q & hist_q;

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receive deserializer: conditions SCLK/LRCLK/SDIN in the MCLK domain and
// assembles MSB-first left/right samples with single-cycle valid strobes.
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SLOT_W = i2s_pkg::SLOT_W
) (
    input  logic              MCLKIN,
    input  logic              RST,
    input  logic              SCLK_IN,
    input  logic              LRCLK_IN,
    input  logic              SDIN,
    output logic [DATA_W-1:0] L_DOUT,
    output logic [DATA_W-1:0] R_DOUT,
    output logic              L_VALID,
    output logic              R_VALID,
    output logic              FRAME_ERR,
    output logic              LOCKED
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] OVR_CNT  = CNT_W'(SLOT_W + 1);

    logic sclk_sync;
    logic sclk_rise_c;
    logic sclk_fall_c;
    logic lr_sync;
    logic lr_rise_c;
    logic lr_fall_c;
    logic unused_edges_c;

    i2s_sync_edge u_sclk_sync (
        .clk_i    (MCLKIN),
        .rst_i    (RST),
        .d_i      (SCLK_IN),
        .sync_o   (sclk_sync),
        .rise_o_c (sclk_rise_c),
        .fall_o_c (sclk_fall_c)
    );

    i2s_sync_edge u_lr_sync (
        .clk_i    (MCLKIN),
        .rst_i    (RST),
        .d_i      (LRCLK_IN),
        .sync_o   (lr_sync),
        .rise_o_c (lr_rise_c),
        .fall_o_c (lr_fall_c)
    );

    assign unused_edges_c = ^{sclk_sync, sclk_fall_c, lr_rise_c, lr_fall_c};

    // SDIN only needs to line up with the synchronised SCLK.
    logic sd_s1_q, sd_s2_q;

    logic lr_smp_q, lr_smp_d;
    logic sd_smp_q, sd_smp_d;
    logic smp_v_q,  smp_v_d;
    logic lr_prev_q, lr_prev_d;
    logic primed_q,  primed_d;

    state_e            state_q,   state_d;
    ch_e               ch_q,      ch_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] sh_q,      sh_d;
    logic [DATA_W-1:0] l_dout_q,  l_dout_d;
    logic [DATA_W-1:0] r_dout_q,  r_dout_d;
    logic              l_valid_q, l_valid_d;
    logic              r_valid_q, r_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              locked_q,  locked_d;

    logic              lr_edge_c;
    logic              last_bit_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [DATA_W-1:0] word_c;
    logic              emit_c;
    logic              restart_c;

    // Sample LRCLK/SDIN on each synchronised SCLK rising edge.
    always_comb begin
        lr_smp_d = lr_smp_q;
        sd_smp_d = sd_smp_q;
        smp_v_d  = sclk_rise_c;
        if (sclk_rise_c) begin
            lr_smp_d = lr_sync;
            sd_smp_d = sd_s2_q;
        end
    end

    // The first sample after reset only primes lr_prev so a mid-slot start
    // never looks like a word-select transition.
    assign lr_edge_c  = smp_v_q & primed_q & (lr_smp_q != lr_prev_q);
    assign last_bit_c = (bit_cnt_q == LAST_BIT);
    assign cnt_inc_c  = sat_inc(bit_cnt_q);
    assign word_c     = {sh_q, sd_smp_q};

    // Slot FSM: next state, shift register, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        l_dout_d    = l_dout_q;
        r_dout_d    = r_dout_q;
        l_valid_d   = 1'b0;
        r_valid_d   = 1'b0;
        frame_err_d = frame_err_q;
        locked_d    = locked_q;
        lr_prev_d   = lr_prev_q;
        primed_d    = primed_q;
        emit_c      = 1'b0;
        restart_c   = 1'b0;

        if (smp_v_q) begin
            lr_prev_d = lr_smp_q;
            primed_d  = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                restart_c = lr_edge_c;
            end
            ST_SHIFT: begin
                if (lr_edge_c) begin
                    // A transition on the LSB edge still completes the word.
                    restart_c = 1'b1;
                    if (last_bit_c) begin
                        emit_c = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (smp_v_q) begin
                    sh_d      = {sh_q[DATA_W-3:0], sd_smp_q};
                    bit_cnt_d = cnt_inc_c;
                    if (last_bit_c) begin
                        emit_c  = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (lr_edge_c) begin
                    restart_c = 1'b1;
                end else if (smp_v_q) begin
                    bit_cnt_d = cnt_inc_c;
                    if (cnt_inc_c == OVR_CNT) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit_c) begin
            if (ch_q == CH_RIGHT) begin
                r_dout_d  = word_c;
                r_valid_d = 1'b1;
            end else begin
                l_dout_d  = word_c;
                l_valid_d = 1'b1;
            end
        end

        // The transition edge is the I2S delay bit; its data is dropped.
        if (restart_c) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
            sh_d      = '0;
            ch_d      = ch_e'(lr_smp_q);
            locked_d  = 1'b1;
        end
    end

    always_ff @(posedge MCLKIN) begin
        if (RST) begin
            sd_s1_q     <= 1'b0;
            sd_s2_q     <= 1'b0;
            lr_smp_q    <= 1'b0;
            sd_smp_q    <= 1'b0;
            smp_v_q     <= 1'b0;
            lr_prev_q   <= 1'b0;
            primed_q    <= 1'b0;
            state_q     <= ST_IDLE;
            ch_q        <= CH_LEFT;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            l_dout_q    <= '0;
            r_dout_q    <= '0;
            l_valid_q   <= 1'b0;
            r_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            sd_s1_q     <= SDIN;
            sd_s2_q     <= sd_s1_q;
            lr_smp_q    <= lr_smp_d;
            sd_smp_q    <= sd_smp_d;
            smp_v_q     <= smp_v_d;
            lr_prev_q   <= lr_prev_d;
            primed_q    <= primed_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            l_dout_q    <= l_dout_d;
            r_dout_q    <= r_dout_d;
            l_valid_q   <= l_valid_d;
            r_valid_q   <= r_valid_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
        end
    end

    assign L_DOUT    = l_dout_q;
    assign R_DOUT    = r_dout_q;
    assign L_VALID   = l_valid_q;
    assign R_VALID   = r_valid_q;
    assign FRAME_ERR = frame_err_q;
    assign LOCKED    = locked_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed bench for i2s_rx_deser: drives I2S at MCLK/8 and checks captured words.
module tb_i2s_rx_deser;
    import i2s_pkg::*;

    localparam int unsigned DW = 16;

    logic          MCLKIN;
    logic          RST;
    logic          SCLK_IN;
    logic          LRCLK_IN;
    logic          SDIN;
    logic [DW-1:0] L_DOUT;
    logic [DW-1:0] R_DOUT;
    logic          L_VALID;
    logic          R_VALID;
    logic          FRAME_ERR;
    logic          LOCKED;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit            ch;
        logic [DW-1:0] data;
        longint        cyc;
    } ev_t;

    ev_t    evq[$];
    longint cyc     = 0;
    int     both_hi = 0;

    i2s_rx_deser #(.DATA_W(DW), .SLOT_W(32)) dut (
        .MCLKIN    (MCLKIN),
        .RST       (RST),
        .SCLK_IN   (SCLK_IN),
        .LRCLK_IN  (LRCLK_IN),
        .SDIN      (SDIN),
        .L_DOUT    (L_DOUT),
        .R_DOUT    (R_DOUT),
        .L_VALID   (L_VALID),
        .R_VALID   (R_VALID),
        .FRAME_ERR (FRAME_ERR),
        .LOCKED    (LOCKED)
    );

    initial MCLKIN = 1'b0;
    always #5 MCLKIN = ~MCLKIN;

    always @(posedge MCLKIN) cyc <= cyc + 1;

    // Record every valid pulse, sampled on the inactive edge.
    always @(negedge MCLKIN) begin
        if (L_VALID && R_VALID) both_hi <= both_hi + 1;
        if (L_VALID) evq.push_back('{1'b0, L_DOUT, cyc});
        if (R_VALID) evq.push_back('{1'b1, R_DOUT, cyc});
    end

    // One SCLK period (8 MCLK): data/LR change on the falling edge.
    task automatic sclk_cycle(input bit lr, input bit sd);
        @(negedge MCLKIN);
        SCLK_IN  = 1'b0;
        LRCLK_IN = lr;
        SDIN     = sd;
        repeat (4) @(negedge MCLKIN);
        SCLK_IN  = 1'b1;
        repeat (3) @(negedge MCLKIN);
    endtask

    // Slot position 0 carries d0 (delay bit / previous LSB); 1..16 carry w MSB first.
    task automatic send_slot(input bit lr, input logic [DW-1:0] w, input int nsclk,
                             input bit d0, input int kstart);
        bit sd;
        for (int k = kstart; k < nsclk; k++) begin
            if (k == 0)       sd = d0;
            else if (k <= 16) sd = w[16-k];
            else              sd = 1'b0;
            sclk_cycle(lr, sd);
        end
    endtask

    task automatic do_reset();
        @(negedge MCLKIN);
        RST      = 1'b1;
        SCLK_IN  = 1'b0;
        LRCLK_IN = 1'b1;
        SDIN     = 1'b0;
        @(negedge MCLKIN);
        RST      = 1'b0;
        repeat (8) @(negedge MCLKIN);
        evq.delete();
        both_hi = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({L_DOUT, R_DOUT, L_VALID, R_VALID, FRAME_ERR, LOCKED} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got L=%h R=%h lv=%b rv=%b err=%b lock=%b required all 0",
                     L_DOUT, R_DOUT, L_VALID, R_VALID, FRAME_ERR, LOCKED);
        end
        tests++;
        if (dut.state_q !== ST_IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d required %0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_slot(1'b1, 16'h0000, 32, 1'b0, 0);
        tests++;
        if (LOCKED !== 1'b0 || evq.size() != 0) begin
            fails++;
            $display("FAIL basic_prelock: got lock=%b events=%0d required 0/0", LOCKED, evq.size());
        end
        send_slot(1'b0, 16'hA5C3, 32, 1'b0, 0);
        send_slot(1'b1, 16'h0F0F, 32, 1'b0, 0);
        repeat (8) @(negedge MCLKIN);
        tests++;
        if (evq.size() != 2) begin
            fails++;
            $display("FAIL basic_count: got %0d events required 2", evq.size());
        end else begin
            tests++;
            if (evq[0].ch !== 1'b0 || evq[0].data !== 16'hA5C3) begin
                fails++;
                $display("FAIL basic_left: got ch=%b %h required ch=0 a5c3", evq[0].ch, evq[0].data);
            end
            tests++;
            if (evq[1].ch !== 1'b1 || evq[1].data !== 16'h0F0F) begin
                fails++;
                $display("FAIL basic_right: got ch=%b %h required ch=1 0f0f", evq[1].ch, evq[1].data);
            end
        end
        tests++;
        if (FRAME_ERR !== 1'b0 || LOCKED !== 1'b1 || L_DOUT !== 16'hA5C3 || R_DOUT !== 16'h0F0F) begin
            fails++;
            $display("FAIL basic_status: got err=%b lock=%b L=%h R=%h required 0 1 a5c3 0f0f",
                     FRAME_ERR, LOCKED, L_DOUT, R_DOUT);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp;
        do_reset();
        send_slot(1'b1, 16'h0000, 32, 1'b0, 0);
        for (int n = 0; n < 8; n++) begin
            send_slot(1'b0, 16'(n), 32, 1'b0, 0);
            send_slot(1'b1, ~16'(n), 32, 1'b0, 0);
        end
        repeat (8) @(negedge MCLKIN);
        tests++;
        if (evq.size() != 16) begin
            fails++;
            $display("FAIL stream_count: got %0d events required 16", evq.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp = (i % 2 == 0) ? 16'(i / 2) : ~16'(i / 2);
                tests++;
                if (evq[i].ch !== 1'(i % 2) || evq[i].data !== exp) begin
                    fails++;
                    $display("FAIL stream_word%0d: got ch=%b %h required ch=%0d %h",
                             i, evq[i].ch, evq[i].data, i % 2, exp);
                end
                if (i > 0) begin
                    tests++;
                    if (evq[i].cyc - evq[i-1].cyc != 256) begin
                        fails++;
                        $display("FAIL stream_gap%0d: got %0d cycles required 256",
                                 i, evq[i].cyc - evq[i-1].cyc);
                    end
                end
            end
        end
        tests++;
        if (both_hi != 0 || FRAME_ERR !== 1'b0) begin
            fails++;
            $display("FAIL stream_status: got both=%0d err=%b required 0 0", both_hi, FRAME_ERR);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        send_slot(1'b1, 16'h0000, 32, 1'b0, 0);
        // 16-SCLK left slot: the LSB lands on the next LRCLK transition edge.
        send_slot(1'b0, 16'h8001, 16, 1'b0, 0);
        send_slot(1'b1, 16'h7FFE, 32, 1'b1, 0);
        repeat (8) @(negedge MCLKIN);
        tests++;
        if (evq.size() != 2) begin
            fails++;
            $display("FAIL simul_count: got %0d events required 2", evq.size());
        end else begin
            tests++;
            if (evq[0].ch !== 1'b0 || evq[0].data !== 16'h8001 ||
                evq[1].ch !== 1'b1 || evq[1].data !== 16'h7FFE) begin
                fails++;
                $display("FAIL simul_words: got %b:%h %b:%h required 0:8001 1:7ffe",
                         evq[0].ch, evq[0].data, evq[1].ch, evq[1].data);
            end
        end
        tests++;
        if (FRAME_ERR !== 1'b0) begin
            fails++;
            $display("FAIL simul_err: got %b required 0", FRAME_ERR);
        end
    endtask

    task automatic test_short_slot();
        do_reset();
        send_slot(1'b1, 16'h0000, 32, 1'b0, 0);
        send_slot(1'b0, 16'hFFFF, 11, 1'b0, 0);
        send_slot(1'b1, 16'h1234, 32, 1'b0, 0);
        repeat (8) @(negedge MCLKIN);
        tests++;
        if (evq.size() != 1) begin
            fails++;
            $display("FAIL short_count: got %0d events required 1", evq.size());
        end else begin
            tests++;
            if (evq[0].ch !== 1'b1 || evq[0].data !== 16'h1234) begin
                fails++;
                $display("FAIL short_right: got ch=%b %h required ch=1 1234", evq[0].ch, evq[0].data);
            end
        end
        tests++;
        if (FRAME_ERR !== 1'b1 || L_DOUT !== 16'h0000) begin
            fails++;
            $display("FAIL short_status: got err=%b L=%h required 1 0000", FRAME_ERR, L_DOUT);
        end
    endtask

    task automatic test_stuck_lrclk();
        do_reset();
        send_slot(1'b1, 16'h0000, 32, 1'b0, 0);
        send_slot(1'b0, 16'hBEEF, 72, 1'b0, 0);
        tests++;
        if (FRAME_ERR !== 1'b1 || dut.state_q !== ST_IDLE) begin
            fails++;
            $display("FAIL stuck_overrun: got err=%b state=%0d required 1 %0d",
                     FRAME_ERR, dut.state_q, ST_IDLE);
        end
        send_slot(1'b1, 16'h5A5A, 32, 1'b0, 0);
        send_slot(1'b0, 16'h1357, 32, 1'b0, 0);
        repeat (8) @(negedge MCLKIN);
        tests++;
        if (evq.size() != 3) begin
            fails++;
            $display("FAIL stuck_count: got %0d events required 3", evq.size());
        end else begin
            tests++;
            if (evq[0].data !== 16'hBEEF || evq[1].ch !== 1'b1 || evq[1].data !== 16'h5A5A ||
                evq[2].ch !== 1'b0 || evq[2].data !== 16'h1357) begin
                fails++;
                $display("FAIL stuck_words: got %h %b:%h %b:%h required beef 1:5a5a 0:1357",
                         evq[0].data, evq[1].ch, evq[1].data, evq[2].ch, evq[2].data);
            end
        end
    endtask

    task automatic test_mid_frame_start();
        do_reset();
        send_slot(1'b1, 16'hFFFF, 32, 1'b1, 7);
        tests++;
        if (evq.size() != 0 || LOCKED !== 1'b0) begin
            fails++;
            $display("FAIL midframe_quiet: got events=%0d lock=%b required 0 0", evq.size(), LOCKED);
        end
        send_slot(1'b0, 16'hC0DE, 32, 1'b0, 0);
        send_slot(1'b1, 16'h0BAD, 32, 1'b0, 0);
        repeat (8) @(negedge MCLKIN);
        tests++;
        if (evq.size() != 2) begin
            fails++;
            $display("FAIL midframe_count: got %0d events required 2", evq.size());
        end else begin
            tests++;
            if (evq[0].ch !== 1'b0 || evq[0].data !== 16'hC0DE ||
                evq[1].ch !== 1'b1 || evq[1].data !== 16'h0BAD) begin
                fails++;
                $display("FAIL midframe_words: got %b:%h %b:%h required 0:c0de 1:0bad",
                         evq[0].ch, evq[0].data, evq[1].ch, evq[1].data);
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        send_slot(1'b1, 16'h0000, 32, 1'b0, 0);
        send_slot(1'b0, 16'h1111, 32, 1'b0, 0);
        send_slot(1'b1, 16'h2222, 32, 1'b0, 0);
        tests++;
        if (L_DOUT !== 16'h1111 || R_DOUT !== 16'h2222 || LOCKED !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: got L=%h R=%h lock=%b required 1111 2222 1",
                     L_DOUT, R_DOUT, LOCKED);
        end
        send_slot(1'b0, 16'h3333, 8, 1'b0, 0);
        evq.delete();
        @(negedge MCLKIN);
        RST = 1'b1;
        @(negedge MCLKIN);
        RST = 1'b0;
        tests++;
        if ({L_DOUT, R_DOUT, L_VALID, R_VALID, FRAME_ERR, LOCKED} !== '0) begin
            fails++;
            $display("FAIL rstmid_clear: got L=%h R=%h lv=%b rv=%b err=%b lock=%b required all 0",
                     L_DOUT, R_DOUT, L_VALID, R_VALID, FRAME_ERR, LOCKED);
        end
        send_slot(1'b0, 16'h3333, 32, 1'b0, 8);
        tests++;
        if (evq.size() != 0 || LOCKED !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_quiet: got events=%0d lock=%b required 0 0", evq.size(), LOCKED);
        end
        send_slot(1'b1, 16'h4444, 32, 1'b0, 0);
        send_slot(1'b0, 16'h5555, 32, 1'b0, 0);
        repeat (8) @(negedge MCLKIN);
        tests++;
        if (evq.size() != 2) begin
            fails++;
            $display("FAIL rstmid_count: got %0d events required 2", evq.size());
        end else begin
            tests++;
            if (evq[0].ch !== 1'b1 || evq[0].data !== 16'h4444 ||
                evq[1].ch !== 1'b0 || evq[1].data !== 16'h5555) begin
                fails++;
                $display("FAIL rstmid_words: got %b:%h %b:%h required 1:4444 0:5555",
                         evq[0].ch, evq[0].data, evq[1].ch, evq[1].data);
            end
        end
        tests++;
        if (LOCKED !== 1'b1 || FRAME_ERR !== 1'b0 || both_hi != 0) begin
            fails++;
            $display("FAIL rstmid_status: got lock=%b err=%b both=%0d required 1 0 0",
                     LOCKED, FRAME_ERR, both_hi);
        end
    endtask

    initial begin
        RST      = 1'b1;
        SCLK_IN  = 1'b0;
        LRCLK_IN = 1'b1;
        SDIN     = 1'b0;
        repeat (3) @(negedge MCLKIN);
        test_reset();
        test_basic();
        test_stream();
        test_simultaneous();
        test_short_slot();
        test_stuck_lrclk();
        test_mid_frame_start();
        test_reset_mid_slot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
